// File: rtl/miriscv_dmem_wait.sv
// Word-organised data memory behind the LSU with a programmable wait-state
// controller; one request at a time, one-cycle registered ready pulse.
module miriscv_dmem_wait #(
  parameter int WORDS       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        mem_ready_o
);

  localparam int IDX_W = $clog2(WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ready_q, ready_d;

  logic              acc_en;
  logic              acc_we;
  logic [3:0]        acc_be;
  logic [IDX_W-1:0]  acc_idx;
  logic [31:0]       acc_wdata;

  logic [31:0]       mem [WORDS];

  logic [IDX_W-1:0]  req_idx;
  logic              unused_addr;

  // Offset bits and bits above the index are dropped, so addresses wrap modulo WORDS.
  assign req_idx     = data_addr_i[IDX_W+1:2];
  assign unused_addr = ^{data_addr_i[31:IDX_W+2], data_addr_i[1:0]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    be_d      = be_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    acc_en    = 1'b0;
    acc_we    = we_q;
    acc_be    = be_q;
    acc_idx   = idx_q;
    acc_wdata = wdata_q;

    case (state_q)
      IDLE: begin
        if (data_req_i) begin
          we_d    = data_we_i;
          be_d    = data_be_i;
          idx_d   = req_idx;
          wdata_d = data_wdata_i;
          if (WAIT_CYCLES == 0) begin
            // Zero wait states: the access happens on the sampling edge itself.
            state_d   = RESP;
            cnt_d     = 4'd0;
            acc_en    = 1'b1;
            acc_we    = data_we_i;
            acc_be    = data_be_i;
            acc_idx   = req_idx;
            acc_wdata = data_wdata_i;
          end else begin
            state_d = BUSY;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          acc_en  = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == RESP);
    rdata_d = (acc_en && !acc_we) ? mem[acc_idx] : rdata_q;
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      be_q    <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      be_q    <= be_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
    end
  end

  // Storage is deliberately not reset; lanes without an enable keep their old bytes.
  always_ff @(posedge clk_i) begin
    if (acc_en && acc_we) begin
      for (int n = 0; n < 4; n++) begin
        if (acc_be[n]) begin
          mem[acc_idx][8*n +: 8] <= acc_wdata[8*n +: 8];
        end
      end
    end
  end

  assign data_rdata_o = rdata_q;
  assign mem_ready_o  = ready_q;

endmodule

// File: tb/tb_miriscv_dmem_wait.sv
// Self-checking bench for miriscv_dmem_wait: three instances (2, 0 and 4 wait
// states) driven by directed and random transactions against a word-array model.
module tb_miriscv_dmem_wait;

  logic        clk;
  logic        rstn  [3];
  logic        req   [3];
  logic        we    [3];
  logic [3:0]  be    [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic        ready [3];

  logic [31:0] mdl_mem   [3][1024];
  logic [31:0] mdl_rdata [3];

  int checks;
  int passed;

  miriscv_dmem_wait #(.WORDS(1024), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk_i(clk), .arstn_i(rstn[0]), .data_req_i(req[0]), .data_we_i(we[0]),
    .data_be_i(be[0]), .data_addr_i(addr[0]), .data_wdata_i(wdata[0]),
    .data_rdata_o(rdata[0]), .mem_ready_o(ready[0]));

  miriscv_dmem_wait #(.WORDS(1024), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk_i(clk), .arstn_i(rstn[1]), .data_req_i(req[1]), .data_we_i(we[1]),
    .data_be_i(be[1]), .data_addr_i(addr[1]), .data_wdata_i(wdata[1]),
    .data_rdata_o(rdata[1]), .mem_ready_o(ready[1]));

  miriscv_dmem_wait #(.WORDS(1024), .WAIT_CYCLES(4)) u_dut_w4 (
    .clk_i(clk), .arstn_i(rstn[2]), .data_req_i(req[2]), .data_we_i(we[2]),
    .data_be_i(be[2]), .data_addr_i(addr[2]), .data_wdata_i(wdata[2]),
    .data_rdata_o(rdata[2]), .mem_ready_o(ready[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wait_of(input int d);
    case (d)
      0:       return 2;
      1:       return 0;
      default: return 4;
    endcase
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % 32'd1024);
  endfunction

  task automatic model_write(input int d, input logic [3:0] b, input logic [31:0] a,
                             input logic [31:0] wd);
    int ix;
    ix = idx_of(a);
    for (int n = 0; n < 4; n++) begin
      if (b[n]) mdl_mem[d][ix][8*n +: 8] = wd[8*n +: 8];
    end
  endtask

  task automatic checkOutput(input string tag, input int d, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s (dut %0d): observed=%h expected=%h", tag, d, obs, exp);
  endtask

  // One complete transaction: request held until the ready pulse, fields
  // scrambled while the controller is waiting, request dropped in the ready cycle.
  task automatic applyStimulus(input int d, input logic w, input logic [3:0] b,
                               input logic [31:0] a, input logic [31:0] wd);
    int wc;
    wc = wait_of(d);
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; be[d] = b; addr[d] = a; wdata[d] = wd;
    @(posedge clk);
    for (int k = 0; k <= wc; k++) begin
      if (k > 0) @(posedge clk);
      #1;
      if (k == 1 && k < wc) begin
        we[d] = 1'($urandom); be[d] = 4'($urandom);
        addr[d] = $urandom; wdata[d] = $urandom;
      end
      checkOutput("ready_timing", d, {31'd0, ready[d]}, {31'd0, (k == wc)});
      if (k < wc) checkOutput("rdata_hold_busy", d, rdata[d], mdl_rdata[d]);
    end
    if (w) model_write(d, b, a, wd);
    else mdl_rdata[d] = mdl_mem[d][idx_of(a)];
    checkOutput("rdata_resp", d, rdata[d], mdl_rdata[d]);
    req[d] = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("ready_drop", d, {31'd0, ready[d]}, 32'd0);
    checkOutput("rdata_hold_idle", d, rdata[d], mdl_rdata[d]);
  endtask

  function automatic logic [31:0] addr_for(input int ix);
    return ($urandom & ~32'h0000_0FFC) | (32'(ix) << 2);
  endfunction

  initial begin
    logic [31:0] seed_word;
    int          ix;
    checks = 0;
    passed = 0;
    for (int d = 0; d < 3; d++) begin
      rstn[d] = 1'b1; req[d] = 1'b0; we[d] = 1'b0; be[d] = 4'h0;
      addr[d] = 32'h0; wdata[d] = 32'h0; mdl_rdata[d] = 32'h0;
    end
    #2;
    for (int d = 0; d < 3; d++) begin
      rstn[d] = 1'b0;
      req[d] = 1'b1; we[d] = 1'b1; be[d] = 4'hF;
      addr[d] = 32'h40; wdata[d] = 32'hC0DE_0000 + 32'(d);
    end

    $display("[TB] reset held with request asserted");
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
        checkOutput("reset_ready", d, {31'd0, ready[d]}, 32'd0);
        checkOutput("reset_rdata", d, rdata[d], 32'd0);
      end
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) rstn[d] = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
        if (k <= wait_of(d))
          checkOutput("release_ready", d, {31'd0, ready[d]}, {31'd0, (k == wait_of(d))});
        if (k == wait_of(d)) begin
          model_write(d, 4'hF, 32'h40, 32'hC0DE_0000 + 32'(d));
          req[d] = 1'b0;
        end
      end
    end
    @(posedge clk);

    $display("[TB] full word write/read, lane merge, wrap");
    applyStimulus(0, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
    applyStimulus(0, 1'b0, 4'h0, 32'h10, 32'h0);
    checkOutput("read_deadbeef", 0, rdata[0], 32'hDEAD_BEEF);
    applyStimulus(0, 1'b1, 4'hF, 32'h0, 32'h1122_3344);
    applyStimulus(0, 1'b1, 4'b0100, 32'h0, 32'hAAAA_AAAA);
    applyStimulus(0, 1'b0, 4'h0, 32'h0, 32'h0);
    checkOutput("lane_merge", 0, rdata[0], 32'h11AA_3344);
    applyStimulus(0, 1'b1, 4'h0, 32'h0, 32'hFFFF_FFFF);
    applyStimulus(0, 1'b0, 4'h0, 32'h0, 32'h0);
    checkOutput("be_zero", 0, rdata[0], 32'h11AA_3344);
    applyStimulus(0, 1'b1, 4'hF, 32'h0000_1000, 32'h5);
    applyStimulus(0, 1'b0, 4'h0, 32'h0, 32'h0);
    checkOutput("wrap_read0", 0, rdata[0], 32'h5);
    applyStimulus(0, 1'b0, 4'h0, 32'h3, 32'h0);
    checkOutput("wrap_read3", 0, rdata[0], 32'h5);

    $display("[TB] random transactions, 2 wait states");
    for (int i = 0; i < 16; i++) applyStimulus(0, 1'b1, 4'hF, addr_for(i), $urandom);
    for (int i = 0; i < 40; i++) begin
      ix = int'($urandom_range(15, 0));
      applyStimulus(0, 1'($urandom), 4'($urandom), addr_for(ix), $urandom);
    end

    $display("[TB] zero wait states, back-to-back reads");
    for (int i = 1; i <= 3; i++) applyStimulus(1, 1'b1, 4'hF, 32'(i) << 2, $urandom);
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'h0; addr[1] = 32'h4; wdata[1] = 32'h0;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk);
      #1;
      checkOutput("b2b_ready", 1, {31'd0, ready[1]}, {31'd0, (e % 2 == 1)});
      if (e % 2 == 1) begin
        mdl_rdata[1] = mdl_mem[1][idx_of(addr[1])];
        checkOutput("b2b_rdata", 1, rdata[1], mdl_rdata[1]);
        addr[1] = addr[1] + 32'h4;
      end else begin
        checkOutput("b2b_rdata_hold", 1, rdata[1], mdl_rdata[1]);
      end
    end
    req[1] = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("b2b_ready_end", 1, {31'd0, ready[1]}, 32'd0);
    checkOutput("b2b_rdata_end", 1, rdata[1], mdl_rdata[1]);
    for (int i = 0; i < 12; i++) begin
      ix = int'($urandom_range(3, 1));
      applyStimulus(1, 1'($urandom), 4'($urandom), addr_for(ix), $urandom);
    end

    $display("[TB] reset during wait states");
    seed_word = 32'h1234_5678;
    applyStimulus(2, 1'b1, 4'hF, 32'h20, seed_word);
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b1; be[2] = 4'hF; addr[2] = 32'h20; wdata[2] = 32'hFFFF_FFFF;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn[2] = 1'b0;
    req[2] = 1'b0;
    mdl_rdata[2] = 32'h0;
    #1;
    checkOutput("busy_reset_ready", 2, {31'd0, ready[2]}, 32'd0);
    checkOutput("busy_reset_rdata", 2, rdata[2], 32'd0);
    @(negedge clk);
    rstn[2] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      checkOutput("busy_reset_no_pulse", 2, {31'd0, ready[2]}, 32'd0);
    end
    applyStimulus(2, 1'b0, 4'h0, 32'h20, 32'h0);
    checkOutput("busy_reset_word_kept", 2, rdata[2], seed_word);

    $display("[TB] reset during ready cycle");
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF; addr[0] = 32'h30; wdata[0] = 32'hCAFE_F00D;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("resp_ready_before_reset", 0, {31'd0, ready[0]}, 32'd1);
    req[0] = 1'b0;
    rstn[0] = 1'b0;
    #1;
    checkOutput("resp_reset_truncate", 0, {31'd0, ready[0]}, 32'd0);
    checkOutput("resp_reset_rdata", 0, rdata[0], 32'd0);
    model_write(0, 4'hF, 32'h30, 32'hCAFE_F00D);
    mdl_rdata[0] = 32'h0;
    @(negedge clk);
    rstn[0] = 1'b1;
    applyStimulus(0, 1'b0, 4'h0, 32'h30, 32'h0);
    checkOutput("resp_reset_write_done", 0, rdata[0], 32'hCAFE_F00D);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
